// File: rtl/stream_fifo.sv
// Single-clock FIFO using all 2^ADDR_WIDTH entries, with selectable FWFT or registered read,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module stream_fifo #(
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned ADDR_WIDTH          = 5,
    parameter int unsigned ALMOST_EMPTY_MARGIN = 2,
    parameter int unsigned ALMOST_FULL_MARGIN  = 2,
    parameter int unsigned FWFT                = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  write_enable_i,
    input  logic                  read_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  read_valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_almost_empty_o,
    output logic                  fifo_almost_full_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY_MARGIN);
    localparam logic [PW-1:0] AF_LVL   = PW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         mem_cnt;
    logic [PW-1:0]         count_next;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  load;

    // Accept logic; in FWFT mode the output register is refilled whenever it is free or being popped.
    always_comb begin
        rd_ok      = 1'b0;
        load       = 1'b0;
        wr_ok      = 1'b0;
        mem_cnt    = wr_ptr - rd_ptr;
        if (FWFT != 0) begin
            rd_ok = read_enable_i && read_valid_o;
            load  = (mem_cnt != '0) && (!read_valid_o || rd_ok);
        end else begin
            rd_ok = read_enable_i && !fifo_empty_o;
            load  = rd_ok;
        end
        wr_ok      = write_enable_i && (!fifo_full_o || rd_ok);
        count_next = count_o + PW'(wr_ok) - PW'(rd_ok);
    end

    // Storage array, not reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush_i) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            read_data_o         <= '0;
            read_valid_o        <= 1'b0;
            count_o             <= '0;
            fifo_empty_o        <= 1'b1;
            fifo_almost_empty_o <= 1'b1;
            fifo_almost_full_o  <= 1'b0;
            fifo_full_o         <= 1'b0;
            overflow_o          <= 1'b0;
            underflow_o         <= 1'b0;
        end else if (flush_i) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            read_valid_o        <= 1'b0;
            count_o             <= '0;
            fifo_empty_o        <= 1'b1;
            fifo_almost_empty_o <= 1'b1;
            fifo_almost_full_o  <= 1'b0;
            fifo_full_o         <= 1'b0;
            overflow_o          <= 1'b0;
            underflow_o         <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Registered read pulses valid per pop; FWFT keeps valid while a head is held.
            if (load) begin
                rd_ptr       <= rd_ptr + PW'(1);
                read_data_o  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                read_valid_o <= 1'b1;
            end else if ((FWFT == 0) || rd_ok) begin
                read_valid_o <= 1'b0;
            end
            count_o             <= count_next;
            fifo_empty_o        <= (count_next == '0);
            fifo_almost_empty_o <= (count_next <= AE_LVL);
            fifo_almost_full_o  <= (count_next >= AF_LVL);
            fifo_full_o         <= (count_next == FULL_LVL);
            if (write_enable_i && !wr_ok) begin
                overflow_o <= 1'b1;
            end
            if (read_enable_i && !rd_ok) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: one FWFT and one registered-read instance, both DEPTH=4.
module tb_stream_fifo;

    logic        clk;
    logic        rst_n;

    logic        f_flush, f_we, f_re;
    logic [15:0] f_wd, f_rd;
    logic        f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un;
    logic [2:0]  f_cnt;

    logic        r_flush, r_we, r_re;
    logic [15:0] r_wd, r_rd;
    logic        r_rv, r_em, r_ae, r_af, r_fu, r_ov, r_un;
    logic [2:0]  r_cnt;

    int total = 0;
    int bad   = 0;

    stream_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ALMOST_EMPTY_MARGIN(2),
                  .ALMOST_FULL_MARGIN(2), .FWFT(1)) dut_f (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush),
        .write_data_i(f_wd), .write_enable_i(f_we), .read_enable_i(f_re),
        .read_data_o(f_rd), .read_valid_o(f_rv), .count_o(f_cnt),
        .fifo_empty_o(f_em), .fifo_almost_empty_o(f_ae), .fifo_almost_full_o(f_af),
        .fifo_full_o(f_fu), .overflow_o(f_ov), .underflow_o(f_un)
    );

    stream_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ALMOST_EMPTY_MARGIN(2),
                  .ALMOST_FULL_MARGIN(2), .FWFT(0)) dut_r (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(r_flush),
        .write_data_i(r_wd), .write_enable_i(r_we), .read_enable_i(r_re),
        .read_data_o(r_rd), .read_valid_o(r_rv), .count_o(r_cnt),
        .fifo_empty_o(r_em), .fifo_almost_empty_o(r_ae), .fifo_almost_full_o(r_af),
        .fifo_full_o(r_fu), .overflow_o(r_ov), .underflow_o(r_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_both();
        f_flush = 1'b1; r_flush = 1'b1;
        cyc();
        f_flush = 1'b0; r_flush = 1'b0;
    endtask

    // Status packed as {valid, empty, almost_empty, almost_full, full, overflow, underflow}
    task automatic test_reset();
        rst_n = 1'b1;
        f_flush = 0; f_we = 0; f_re = 0; f_wd = '0;
        r_flush = 0; r_we = 0; r_re = 0; r_wd = '0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un} !== 7'b0110000) begin
            bad++; $display("FAIL reset_f_status got=%b exp=%b", {f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un}, 7'b0110000);
        end
        total++;
        if (f_cnt !== 3'd0 || f_rd !== 16'h0000) begin
            bad++; $display("FAIL reset_f_cnt_data got=%0d/%h exp=0/0000", f_cnt, f_rd);
        end
        total++;
        if ({r_rv, r_em, r_ae, r_af, r_fu, r_ov, r_un} !== 7'b0110000) begin
            bad++; $display("FAIL reset_r_status got=%b exp=%b", {r_rv, r_em, r_ae, r_af, r_fu, r_ov, r_un}, 7'b0110000);
        end
        total++;
        if (r_cnt !== 3'd0 || r_rd !== 16'h0000) begin
            bad++; $display("FAIL reset_r_cnt_data got=%0d/%h exp=0/0000", r_cnt, r_rd);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        total++;
        if ({f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un} !== 7'b0110000) begin
            bad++; $display("FAIL idle_f_status got=%b exp=%b", {f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un}, 7'b0110000);
        end
    endtask

    task automatic test_fwft_fill();
        f_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_wd = 16'hA001 + 16'(i);
            cyc();
        end
        total++;
        if (f_fu !== 1'b1 || f_cnt !== 3'd4) begin
            bad++; $display("FAIL fill_full got=full%b/cnt%0d exp=full1/cnt4", f_fu, f_cnt);
        end
        f_wd = 16'hA005;
        cyc();
        f_we = 1'b0;
        total++;
        if (f_ov !== 1'b1 || f_cnt !== 3'd4) begin
            bad++; $display("FAIL fill_overflow got=ov%b/cnt%0d exp=ov1/cnt4", f_ov, f_cnt);
        end
        f_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (f_rv !== 1'b1 || f_rd !== 16'hA001 + 16'(i)) begin
                bad++; $display("FAIL fill_pop%0d got=v%b/%h exp=v1/%h", i, f_rv, f_rd, 16'hA001 + 16'(i));
            end
            cyc();
        end
        f_re = 1'b0;
        total++;
        if (f_cnt !== 3'd0 || f_em !== 1'b1 || f_rv !== 1'b0) begin
            bad++; $display("FAIL fill_drained got=cnt%0d/em%b/v%b exp=cnt0/em1/v0", f_cnt, f_em, f_rv);
        end
    endtask

    task automatic test_full_simul();
        logic [15:0] exp;
        flush_both();
        f_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_wd = 16'(i + 1);
            cyc();
        end
        f_wd = 16'hBEEF; f_re = 1'b1;
        cyc();
        f_we = 1'b0;
        total++;
        if (f_ov !== 1'b0 || f_cnt !== 3'd4 || f_fu !== 1'b1) begin
            bad++; $display("FAIL simul_full got=ov%b/cnt%0d/full%b exp=ov0/cnt4/full1", f_ov, f_cnt, f_fu);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (i < 3) ? 16'(i + 2) : 16'hBEEF;
            total++;
            if (f_rv !== 1'b1 || f_rd !== exp) begin
                bad++; $display("FAIL simul_pop%0d got=v%b/%h exp=v1/%h", i, f_rv, f_rd, exp);
            end
            cyc();
        end
        f_re = 1'b0;
        total++;
        if (f_cnt !== 3'd0) begin
            bad++; $display("FAIL simul_drained got=%0d exp=0", f_cnt);
        end
    endtask

    task automatic test_wrap();
        int exp_cnt;
        int nxt_push;
        int nxt_pop;
        logic [3:0] exp_flags;
        exp_cnt = 0; nxt_push = 0; nxt_pop = 0;
        flush_both();
        for (int step = 0; step < 16; step++) begin
            f_we = (step < 12);
            f_re = (step >= 4);
            f_wd = 16'h0100 + 16'(nxt_push);
            if (f_re) begin
                total++;
                if (f_rv !== 1'b1 || f_rd !== 16'h0100 + 16'(nxt_pop)) begin
                    bad++; $display("FAIL wrap_data step%0d got=v%b/%h exp=v1/%h", step, f_rv, f_rd, 16'h0100 + 16'(nxt_pop));
                end
            end
            cyc();
            if (f_we) begin exp_cnt++; nxt_push++; end
            if (f_re) begin exp_cnt--; nxt_pop++; end
            exp_flags = {exp_cnt <= 2, exp_cnt >= 2, exp_cnt == 4, exp_cnt == 0};
            total++;
            if ({f_ae, f_af, f_fu, f_em} !== exp_flags || f_cnt !== 3'(exp_cnt)) begin
                bad++; $display("FAIL wrap_flags step%0d got=%b/cnt%0d exp=%b/cnt%0d", step, {f_ae, f_af, f_fu, f_em}, f_cnt, exp_flags, exp_cnt);
            end
        end
        f_we = 1'b0; f_re = 1'b0;
    endtask

    task automatic test_flush();
        flush_both();
        f_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f_wd = 16'h0200 + 16'(i);
            cyc();
        end
        f_we = 1'b0; f_re = 1'b1;
        cyc();
        f_re = 1'b0;
        total++;
        if (f_cnt !== 3'd3 || f_ov !== 1'b1) begin
            bad++; $display("FAIL flush_setup got=cnt%0d/ov%b exp=cnt3/ov1", f_cnt, f_ov);
        end
        f_flush = 1'b1; f_we = 1'b1; f_wd = 16'hDEAD;
        cyc();
        f_flush = 1'b0; f_we = 1'b0;
        total++;
        if (f_cnt !== 3'd0 || f_em !== 1'b1 || f_ov !== 1'b0 || f_rv !== 1'b0) begin
            bad++; $display("FAIL flush_clear got=cnt%0d/em%b/ov%b/v%b exp=cnt0/em1/ov0/v0", f_cnt, f_em, f_ov, f_rv);
        end
        cyc();
        total++;
        if (f_cnt !== 3'd0 || f_rv !== 1'b0) begin
            bad++; $display("FAIL flush_discard got=cnt%0d/v%b exp=cnt0/v0", f_cnt, f_rv);
        end
        f_we = 1'b1; f_wd = 16'h7777;
        cyc();
        f_we = 1'b0;
        cyc();
        total++;
        if (f_rv !== 1'b1 || f_rd !== 16'h7777 || f_cnt !== 3'd1) begin
            bad++; $display("FAIL flush_repush got=v%b/%h/cnt%0d exp=v1/7777/cnt1", f_rv, f_rd, f_cnt);
        end
    endtask

    task automatic test_regread_underflow();
        flush_both();
        r_re = 1'b1;
        cyc();
        r_re = 1'b0;
        total++;
        if (r_rv !== 1'b0 || r_un !== 1'b1) begin
            bad++; $display("FAIL rr_underflow got=v%b/un%b exp=v0/un1", r_rv, r_un);
        end
        r_we = 1'b1; r_wd = 16'h1234;
        cyc();
        r_we = 1'b0;
        total++;
        if (r_cnt !== 3'd1 || r_rv !== 1'b0) begin
            bad++; $display("FAIL rr_push got=cnt%0d/v%b exp=cnt1/v0", r_cnt, r_rv);
        end
        r_re = 1'b1;
        cyc();
        r_re = 1'b0;
        total++;
        if (r_rv !== 1'b1 || r_rd !== 16'h1234 || r_cnt !== 3'd0) begin
            bad++; $display("FAIL rr_pop got=v%b/%h/cnt%0d exp=v1/1234/cnt0", r_rv, r_rd, r_cnt);
        end
        cyc();
        total++;
        if (r_rv !== 1'b0) begin
            bad++; $display("FAIL rr_pulse got=v%b exp=v0", r_rv);
        end
        flush_both();
        r_we = 1'b1; r_re = 1'b1; r_wd = 16'h5555;
        cyc();
        r_we = 1'b0; r_re = 1'b0;
        total++;
        if (r_cnt !== 3'd1 || r_rv !== 1'b0 || r_un !== 1'b1) begin
            bad++; $display("FAIL rr_push_empty got=cnt%0d/v%b/un%b exp=cnt1/v0/un1", r_cnt, r_rv, r_un);
        end
        r_re = 1'b1;
        cyc();
        r_re = 1'b0;
        total++;
        if (r_rv !== 1'b1 || r_rd !== 16'h5555) begin
            bad++; $display("FAIL rr_push_empty_pop got=v%b/%h exp=v1/5555", r_rv, r_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033; vals[3] = 16'h0044;
        flush_both();
        r_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_wd = vals[i];
            cyc();
        end
        r_wd = vals[3];
        r_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            r_we = 1'b0;
            total++;
            if (r_rv !== 1'b1 || r_rd !== vals[i]) begin
                bad++; $display("FAIL b2b_pop%0d got=v%b/%h exp=v1/%h", i, r_rv, r_rd, vals[i]);
            end
        end
        r_re = 1'b0;
        cyc();
        total++;
        if (r_rv !== 1'b0 || r_cnt !== 3'd0) begin
            bad++; $display("FAIL b2b_end got=v%b/cnt%0d exp=v0/cnt0", r_rv, r_cnt);
        end
    endtask

    task automatic test_async_reset();
        flush_both();
        f_we = 1'b1; r_we = 1'b1;
        f_wd = 16'h0A0A; r_wd = 16'h0B0B;
        cyc(); cyc();
        f_we = 1'b0; r_we = 1'b0;
        cyc();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un} !== 7'b0110000 || f_cnt !== 3'd0 || f_rd !== 16'h0) begin
            bad++; $display("FAIL async_f got=%b/cnt%0d/%h exp=0110000/cnt0/0000", {f_rv, f_em, f_ae, f_af, f_fu, f_ov, f_un}, f_cnt, f_rd);
        end
        total++;
        if ({r_rv, r_em, r_ae, r_af, r_fu, r_ov, r_un} !== 7'b0110000 || r_cnt !== 3'd0 || r_rd !== 16'h0) begin
            bad++; $display("FAIL async_r got=%b/cnt%0d/%h exp=0110000/cnt0/0000", {r_rv, r_em, r_ae, r_af, r_fu, r_ov, r_un}, r_cnt, r_rd);
        end
        #2 rst_n = 1'b1;
        cyc();
        total++;
        if (f_cnt !== 3'd0 || f_rv !== 1'b0) begin
            bad++; $display("FAIL async_f_lost got=cnt%0d/v%b exp=cnt0/v0", f_cnt, f_rv);
        end
        r_re = 1'b1;
        cyc();
        r_re = 1'b0;
        total++;
        if (r_rv !== 1'b0 || r_un !== 1'b1) begin
            bad++; $display("FAIL async_r_lost got=v%b/un%b exp=v0/un1", r_rv, r_un);
        end
    endtask

    initial begin
        test_reset();
        test_fwft_fill();
        test_full_simul();
        test_wrap();
        test_flush();
        test_regread_underflow();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
